// File: rtl/tile_fb_pkg.sv
// Shared types and constants for the tile framebuffer: write-FSM states,
// packet header bytes and the RAM address-width helper.
package tile_fb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ROW   = 3'd1,
        ST_COL   = 3'd2,
        ST_CHI   = 3'd3,
        ST_CLO   = 3'd4,
        ST_CLEAR = 3'd5
    } fb_state_t;

    localparam logic [7:0] HDR_WRITE = 8'h55;
    localparam logic [7:0] HDR_CLEAR = 8'hCC;

    // Address width for a RAM of the given depth; never narrower than 1 bit.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/tile_framebuffer_if.sv
// Pixel-path and UART-byte signals of the tile framebuffer.
// rx_valid is a one-cycle strobe with no ready: the framebuffer consumes every
// byte it is offered, and a byte it cannot use is dropped with a frame_err pulse.
interface tile_framebuffer_if #(
    parameter int COLOUR_W = 12
);
    logic [9:0]          h_count;
    logic [9:0]          v_count;
    logic                video_on;
    logic [COLOUR_W-1:0] rgb_colour;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                busy;
    logic                frame_err;

    modport master (
        output h_count, v_count, video_on, rx_data, rx_valid,
        input  rgb_colour, busy, frame_err
    );

    modport slave (
        input  h_count, v_count, video_on, rx_data, rx_valid,
        output rgb_colour, busy, frame_err
    );
endinterface

// File: rtl/tile_ram.sv
// Simple dual-port tile RAM: one write port, one registered read port,
// read-first on a same-address collision. Storage itself is not reset.
module tile_ram
    import tile_fb_pkg::*;
#(
    parameter int DEPTH = 300,
    parameter int WIDTH = 12,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of the pre-write contents gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tile_framebuffer.sv
// Run-time writable tile framebuffer: a 2-stage pixel read path and a
// UART packet FSM (write one tile / clear all tiles) sharing one tile RAM.
module tile_framebuffer
    import tile_fb_pkg::*;
#(
    parameter int H_TILES    = 20,
    parameter int V_TILES    = 15,
    parameter int TILE_SHIFT = 5,
    parameter int COLOUR_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    tile_framebuffer_if.slave  bus,
    output fb_state_t          fsm_state
);

    localparam int DEPTH = H_TILES * V_TILES;
    localparam int AW    = addr_width(DEPTH);

    localparam logic [9:0]    H_LIM10 = 10'(H_TILES);
    localparam logic [9:0]    V_LIM10 = 10'(V_TILES);
    localparam logic [7:0]    H_LIM8  = 8'(H_TILES);
    localparam logic [7:0]    V_LIM8  = 8'(V_TILES);
    localparam logic [AW-1:0] H_MUL   = AW'(H_TILES);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    // ---------------- read path ----------------
    logic [9:0]          rd_row;
    logic [9:0]          rd_col;
    logic                rd_inrange;
    logic [AW-1:0]       rd_addr;
    logic [COLOUR_W-1:0] ram_q;
    logic                video_on_d;
    logic                inrange_d;
    logic [COLOUR_W-1:0] rgb_q;

    assign rd_row     = bus.v_count >> TILE_SHIFT;
    assign rd_col     = bus.h_count >> TILE_SHIFT;
    assign rd_inrange = (rd_row < V_LIM10) && (rd_col < H_LIM10);

    // Off-grid pixels read address 0; their data is masked in stage 2 anyway.
    always_comb begin
        rd_addr = '0;
        if (rd_inrange) begin
            rd_addr = AW'(rd_row) * H_MUL + AW'(rd_col);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            video_on_d <= 1'b0;
            inrange_d  <= 1'b0;
            rgb_q      <= '0;
        end else begin
            video_on_d <= bus.video_on;
            inrange_d  <= rd_inrange;
            rgb_q      <= (video_on_d && inrange_d) ? ram_q : '0;
        end
    end

    assign bus.rgb_colour = rgb_q;

    // ---------------- write FSM ----------------
    fb_state_t           state;
    fb_state_t           state_nxt;
    logic [7:0]          row_q;
    logic [7:0]          col_q;
    logic [7:0]          hi_q;
    logic [AW-1:0]       clr_addr;
    logic                clr_last;
    logic                pkt_inrange;
    logic [AW-1:0]       pkt_addr;
    logic [15:0]         colour_word;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [COLOUR_W-1:0] wdata;
    logic                busy;
    logic                frame_err;

    assign clr_last    = (clr_addr == LAST);
    assign pkt_inrange = (row_q < V_LIM8) && (col_q < H_LIM8);
    assign pkt_addr    = AW'(row_q) * H_MUL + AW'(col_q);
    assign colour_word = {hi_q, bus.rx_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == HDR_WRITE) begin
                        state_nxt = ST_ROW;
                    end else if (bus.rx_data == HDR_CLEAR) begin
                        state_nxt = ST_CLEAR;
                    end
                end
            end
            ST_ROW:   if (bus.rx_valid) state_nxt = ST_COL;
            ST_COL:   if (bus.rx_valid) state_nxt = ST_CHI;
            ST_CHI:   if (bus.rx_valid) state_nxt = ST_CLO;
            ST_CLO:   if (bus.rx_valid) state_nxt = ST_IDLE;
            ST_CLEAR: if (clr_last) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        we        = 1'b0;
        waddr     = '0;
        wdata     = '0;
        busy      = 1'b0;
        frame_err = 1'b0;
        case (state)
            ST_CLO: begin
                if (bus.rx_valid) begin
                    if (pkt_inrange) begin
                        we    = 1'b1;
                        waddr = pkt_addr;
                        wdata = colour_word[COLOUR_W-1:0];
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                busy      = 1'b1;
                we        = 1'b1;
                waddr     = clr_addr;
                frame_err = bus.rx_valid;
            end
            default: ;
        endcase
        if (rst) begin
            we        = 1'b0;
            frame_err = 1'b0;
        end
    end

    // Packet fields and the sweep pointer; the pointer rearms whenever the FSM leaves CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q    <= '0;
            col_q    <= '0;
            hi_q     <= '0;
            clr_addr <= '0;
        end else begin
            if (bus.rx_valid) begin
                case (state)
                    ST_ROW:  row_q <= bus.rx_data;
                    ST_COL:  col_q <= bus.rx_data;
                    ST_CHI:  hi_q  <= bus.rx_data;
                    default: ;
                endcase
            end
            if (state != ST_CLEAR) begin
                clr_addr <= '0;
            end else if (!clr_last) begin
                clr_addr <= clr_addr + AW'(1);
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.frame_err = frame_err;
    assign fsm_state     = state;

    tile_ram #(
        .DEPTH (DEPTH),
        .WIDTH (COLOUR_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

endmodule

// File: doc/tile_framebuffer.md
Name: tile_framebuffer

Overview:
Writable successor to the fixed image ROM. Holds a V_TILES x H_TILES grid of COLOUR_W-bit tile colours in on-chip RAM and serves the VGA pixel path from it. Tiles are updated at run time from a UART receive byte stream using a small packet protocol. Sits between uart_rx and the VGA sync/colour output stage.

Parameters:
H_TILES, 20, tiles per row.
V_TILES, 15, tile rows.
TILE_SHIFT, 5, log2 of the tile edge in pixels; 5 gives 32x32-pixel tiles.
COLOUR_W, 12, colour width in bits; legal range 1..16.

Ports:
clk  in  1  pixel/system clock
rst  in  1  synchronous, active-high reset
h_count  in  10  horizontal pixel counter from VGA timing
v_count  in  10  vertical line counter from VGA timing
video_on  in  1  high in the visible area
rgb_colour  out  COLOUR_W  pixel colour, 2-cycle latency from h_count/v_count
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe, rx_data valid
busy  out  1  high during a clear sweep
frame_err  out  1  one-cycle pulse on a rejected packet or a dropped byte

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst).
- Address mapping: row = v_count>>TILE_SHIFT, col = h_count>>TILE_SHIFT, addr = row*H_TILES + col. Depth = H_TILES*V_TILES. Address width = clog2(depth).
- Read pipeline:
  - Stage 1 registers the RAM read, plus video_on and an in-range flag (row<V_TILES and col<H_TILES).
  - Stage 2 registers rgb_colour = (video_on_d && inrange_d) ? ram_q : 0.
  - Latency is exactly 2 clocks. Throughput is one pixel per clock.
- Write FSM states: IDLE, ROW, COL, CHI, CLO, CLEAR. Each transition happens only on a cycle with rx_valid=1, except inside CLEAR.
  - IDLE: 0x55 -> ROW. 0xCC -> CLEAR. Any other byte is ignored silently.
  - ROW: latch row -> COL.
  - COL: latch col -> CHI.
  - CHI: latch hi byte -> CLO.
  - CLO: colour = {hi,lo}[COLOUR_W-1:0].
    - If row<V_TILES and col<H_TILES: write the RAM on this cycle.
    - Otherwise: no write, frame_err pulses for 1 cycle.
    - Either way -> IDLE.
  - CLEAR: busy=1. Writes 0 to addr 0..depth-1, one address per cycle, then -> IDLE with busy=0 on the following cycle.
    - rx_valid during CLEAR: byte dropped, frame_err pulses.
- Reset:
  - FSM enters CLEAR. busy=1 from the first cycle after rst deasserts, for depth cycles.
  - rgb_colour=0, frame_err=0, pipeline registers=0.
  - RAM contents are only initialised by the sweep.
  - rst asserted mid-packet or mid-sweep aborts it and restarts the sweep from address 0.
- Read and write to the same address in the same cycle: the read returns the old data (read-first).
- The read path is never stalled by writes or clears. During a sweep, the display shows a mix of old and zeroed tiles.
- No timeout on a partial packet. The FSM waits indefinitely for the next byte.

Decomposition:
- Package tile_fb_pkg holds:
  - the FSM state enum
  - the header constants HDR_WRITE=8'h55 and HDR_CLEAR=8'hCC
  - a depth/address-width helper function
- Sub-module tile_ram: simple dual-port RAM with one write port and one synchronous read port, read-first, parametrised by DEPTH and WIDTH. No reset on storage.

Test Plan:
- Release rst, hold rx_valid=0 -> busy=1 for exactly 300 cycles then 0. Read any visible pixel (h=100, v=100) with video_on=1 -> rgb_colour=12'h000 two cycles later.
- After the clear, send 55 03 07 0F 00 -> addr 67 holds 12'hF00. With h=230, v=100, video_on=1 -> rgb_colour=12'hF00 two cycles later. Neighbouring tile h=260 -> 12'h000.
- Send 55 0F 02 0A BC (row 15 is out of range) -> frame_err pulses once on the CLO byte, no RAM change. A re-read of addr 67 still gives 12'hF00.
- Read/write collision: issue the CLO byte of 55 00 00 01 23 in the same cycle that addr 0 is presented -> that pixel returns the old value. The next frame's read returns 12'h123.
- Send CC, then 55 during the sweep -> busy=1 for 300 cycles, frame_err pulses on the dropped 55, and the FSM returns to IDLE. All tiles read 12'h000. video_on=0 always gives 12'h000.
- Assert rst midway through packet 55 01 -> after reset, the sweep runs and the FSM is in IDLE. A fresh 55 00 01 00 F0 writes 12'h0F0 to addr 1.
